instr_trace_fifo: RTL and testbench
===================================

INSTR_TRACE_FIFO -- requirements
Module: instr_trace_fifo

Interface
REQ-001 Parameter DEPTH, 8, number of trace entries; power of two, 2..64.
REQ-002 Parameter AW, 3, pointer width, equal to log2(DEPTH).
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Arm  input  1  one-cycle pulse that starts a capture session.
REQ-006 TrigPC  input  32  PC value that opens capture.
REQ-007 StopOnFull  input  1  1 means halt capture when full; 0 means drop and count.
REQ-008 TrValid  input  1  a retired instruction is presented this cycle (one per CPU clock).
REQ-009 TrPC  input  32  PC of the retired instruction (CPU PCOut).
REQ-010 TrRegWr  input  1  retired instruction wrote the register file.
REQ-011 TrWrAddr  input  5  register write address (CPU WrAddr).
REQ-012 TrWrData  input  32  register write data (CPU RegWrData).
REQ-013 OutValid  output  1  a trace record is available at the head.
REQ-014 OutReady  input  1  consumer accepts the head record when OutValid=1.
REQ-015 OutRec  output  70  head record {RegWr, WrAddr[4:0], PC[31:0], WrData[31:0]}.
REQ-016 Count  output  AW+1  number of stored records, 0..DEPTH.
REQ-017 Dropped  output  16  records lost to overflow; saturates at 16'hFFFF.
REQ-018 State  output  2  session state: 0=IDLE, 1=ARMED, 2=CAPTURE, 3=HALTED.

Function
REQ-019 The session FSM transitions are:
- IDLE to ARMED on Arm.
- ARMED to CAPTURE in the cycle TrValid=1 and TrPC==TrigPC.
- CAPTURE to HALTED when a push is attempted with Count==DEPTH and StopOnFull=1.
- Any state to ARMED on Arm. This re-arm clears the FIFO pointers, Count and Dropped in the same edge.
REQ-020 The triggering instruction is itself captured; it is pushed in the same edge that enters CAPTURE.
REQ-021 A push occurs on a rising edge when TrValid=1 and either State is CAPTURE or the trigger condition holds in ARMED.
REQ-022 The record written is {TrRegWr, TrWrAddr, TrPC, TrWrData}, sampled at that edge.
REQ-023 A pop occurs on a rising edge when OutValid=1 and OutReady=1; the head advances by one.
REQ-024 OutValid equals (Count!=0). OutRec is the head entry, combinational from storage, and is stable while OutValid=1 and OutReady=0.
REQ-025 Zero-latency fall-through is not provided: a record pushed at edge N is visible on OutRec after edge N.
REQ-026 Push and pop in the same edge with Count in 1..DEPTH-1: both occur and Count is unchanged.
REQ-027 Push and pop in the same edge with Count==DEPTH: the pop frees a slot and the push succeeds. Count stays DEPTH, no drop, no halt.
REQ-028 Push and pop in the same edge with Count==0: only the push takes effect. Count becomes 1.
REQ-029 Push attempted with Count==DEPTH, no pop, StopOnFull=0: the record is discarded and Dropped increments, saturating.
REQ-030 Push attempted with Count==DEPTH, no pop, StopOnFull=1: the record is discarded and State goes to HALTED. Dropped is unchanged.
REQ-031 In HALTED and IDLE no pushes occur; pops continue normally until empty.
REQ-032 Read and write pointers are AW bits and wrap modulo DEPTH. Count is tracked separately, so full and empty are unambiguous.
REQ-033 Arm coincident with a push or pop: Arm wins. The push and pop are ignored and the FIFO reads empty after the edge.
REQ-034 Arm coincident with a trigger match: the FSM enters ARMED only; a match is evaluated from the next cycle.
REQ-035 TrValid=0 cycles have no effect on any state.

Reset
REQ-036 Asserting Reset (low) immediately, independent of Clk:
- forces State=IDLE;
- zeroes the pointers, Count and Dropped;
- drives OutValid=0.
REQ-037 OutRec value is don't-care while OutValid=0. Storage contents are not required to reset.
REQ-038 Release of Reset is synchronous to Clk. The first state change occurs on the first rising edge with Reset high.
REQ-039 Reset asserted mid-capture discards all stored records; Dropped reads 0 afterwards.

Verification
REQ-040 Reset low, then high: State=0, Count=0, OutValid=0, Dropped=0 before any Clk edge.
REQ-041 Arm, TrigPC=32'h0000_0010, TrValid each cycle with TrPC=0,4,8,16,20 and OutReady=0:
- State=2 after PC 16;
- Count=2;
- head OutRec PC field=32'h10.
REQ-042 DEPTH=8, StopOnFull=0, OutReady=0, 12 pushes in CAPTURE: Count=8, Dropped=4, State=2, head PC = first captured PC.
REQ-043 Same stimulus with StopOnFull=1: Count=8, Dropped=0, State=3. Then hold OutReady=1 for 8 cycles: records pop in push order, Count=0, OutValid=0.
REQ-044 Full FIFO, push and pop in the same edge: Count stays 8 and the new record appears 8 pops later. Arm pulse during CAPTURE with Count=5: Count=0, State=1 next cycle.

Source files
------------

// File: rtl/instr_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module  : instr_trace_fifo
// Brief   : Trigger-armed capture FIFO of retired-instruction trace records.
// Rev     : 1.0 - initial release
// ============================================================================
module instr_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Arm,
  input  logic [31:0]   TrigPC,
  input  logic          StopOnFull,
  input  logic          TrValid,
  input  logic [31:0]   TrPC,
  input  logic          TrRegWr,
  input  logic [4:0]    TrWrAddr,
  input  logic [31:0]   TrWrData,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [69:0]   OutRec,
  output logic [AW:0]   Count,
  output logic [15:0]   Dropped,
  output logic [1:0]    State
);

  localparam logic [1:0]    c_stIdle    = 2'd0;
  localparam logic [1:0]    c_stArmed   = 2'd1;
  localparam logic [1:0]    c_stCapture = 2'd2;
  localparam logic [1:0]    c_stHalted  = 2'd3;
  localparam logic [AW:0]   c_fullCount = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_countOne  = (AW+1)'(1);
  localparam logic [AW-1:0] c_ptrOne    = AW'(1);

  logic [1:0]    r_state;
  logic [1:0]    w_nextState;
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] r_wrPtr;
  logic [AW:0]   r_count;
  logic [15:0]   r_dropped;
  logic [69:0]   r_mem [DEPTH];

  logic w_trigHit;
  logic w_pushReq;
  logic w_popReq;
  logic w_full;
  logic w_push;
  logic w_overflow;
  logic w_drop;
  logic w_halt;

  // Arm overrides everything else on the same edge, so it gates both requests.
  assign w_trigHit  = (r_state == c_stArmed) && TrValid && (TrPC == TrigPC);
  assign w_pushReq  = !Arm && TrValid && ((r_state == c_stCapture) || w_trigHit);
  assign w_popReq   = !Arm && (r_count != '0) && OutReady;
  assign w_full     = (r_count == c_fullCount);
  assign w_push     = w_pushReq && (!w_full || w_popReq);
  assign w_overflow = w_pushReq && w_full && !w_popReq;
  assign w_drop     = w_overflow && !StopOnFull;
  assign w_halt     = w_overflow && StopOnFull;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= c_stIdle;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (Arm) begin
      w_nextState = c_stArmed;
    end else begin
      case (r_state)
        c_stArmed:   if (w_trigHit) w_nextState = c_stCapture;
        c_stCapture: if (w_halt)    w_nextState = c_stHalted;
        default:     w_nextState = r_state;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rdPtr   <= '0;
      r_wrPtr   <= '0;
      r_count   <= '0;
      r_dropped <= '0;
    end else if (Arm) begin
      r_rdPtr   <= '0;
      r_wrPtr   <= '0;
      r_count   <= '0;
      r_dropped <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + c_ptrOne;
      end
      if (w_popReq) begin
        r_rdPtr <= r_rdPtr + c_ptrOne;
      end
      case ({w_push, w_popReq})
        2'b10:   r_count <= r_count + c_countOne;
        2'b01:   r_count <= r_count - c_countOne;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_dropped != 16'hFFFF)) begin
        r_dropped <= r_dropped + 16'd1;
      end
    end
  end

  // Storage carries no reset; validity is tracked entirely by the count.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {TrRegWr, TrWrAddr, TrPC, TrWrData};
    end
  end

  always_comb begin
    State    = r_state;
    OutValid = (r_count != '0);
    Count    = r_count;
    Dropped  = r_dropped;
    OutRec   = r_mem[r_rdPtr];
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_trace_fifo
// Brief   : Self-checking bench for instr_trace_fifo with a queue-based model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_instr_trace_fifo;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        Clk        = 1'b0;
  logic        Reset      = 1'b1;
  logic        Arm        = 1'b0;
  logic [31:0] TrigPC     = '0;
  logic        StopOnFull = 1'b0;
  logic        TrValid    = 1'b0;
  logic [31:0] TrPC       = '0;
  logic        TrRegWr    = 1'b0;
  logic [4:0]  TrWrAddr   = '0;
  logic [31:0] TrWrData   = '0;
  logic        OutReady   = 1'b0;
  logic        OutValid;
  logic [69:0] OutRec;
  logic [AW:0] Count;
  logic [15:0] Dropped;
  logic [1:0]  State;

  int nChecks = 0;
  int nFail   = 0;

  logic [69:0] mQ[$];
  logic [1:0]  mState   = 2'd0;
  logic [15:0] mDropped = '0;

  always #5 Clk = ~Clk;

  instr_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset), .Arm(Arm), .TrigPC(TrigPC), .StopOnFull(StopOnFull),
    .TrValid(TrValid), .TrPC(TrPC), .TrRegWr(TrRegWr), .TrWrAddr(TrWrAddr),
    .TrWrData(TrWrData), .OutValid(OutValid), .OutReady(OutReady), .OutRec(OutRec),
    .Count(Count), .Dropped(Dropped), .State(State)
  );

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mState   = 2'd0;
    mDropped = '0;
  endtask

  // Applies the rules for one rising edge using the inputs currently driven.
  task automatic modelStep();
    logic [69:0] rec;
    bit full, pop, push;
    if (Arm) begin
      mQ.delete();
      mState   = 2'd1;
      mDropped = '0;
      return;
    end
    full = (mQ.size() == DEPTH);
    pop  = (mQ.size() > 0) && OutReady;
    push = TrValid && ((mState == 2'd2) || ((mState == 2'd1) && (TrPC == TrigPC)));
    rec  = {TrRegWr, TrWrAddr, TrPC, TrWrData};
    if (pop) void'(mQ.pop_front());
    if (push) begin
      if (full && !pop) begin
        if (StopOnFull) mState = 2'd3;
        else if (mDropped != 16'hFFFF) mDropped = mDropped + 16'd1;
      end else begin
        mQ.push_back(rec);
        if (mState == 2'd1) mState = 2'd2;
      end
    end
  endtask

  task automatic compare();
    chk("state", 70'(State), 70'(mState));
    chk("count", 70'(Count), 70'(mQ.size()));
    chk("outValid", 70'(OutValid), 70'(mQ.size() != 0));
    chk("dropped", 70'(Dropped), 70'(mDropped));
    if (mQ.size() > 0) chk("outRec", OutRec, mQ[0]);
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic cycle();
    modelStep();
    @(posedge Clk);
    #1;
    @(negedge Clk);
    compare();
  endtask

  task automatic drive(input bit valid, input logic [31:0] pc);
    TrValid  = valid;
    TrPC     = pc;
    TrRegWr  = 1'($urandom);
    TrWrAddr = 5'($urandom);
    TrWrData = $urandom;
  endtask

  task automatic armPulse();
    Arm     = 1'b1;
    TrValid = 1'b0;
    cycle();
    Arm     = 1'b0;
  endtask

  task automatic asyncReset();
    #2 Reset = 1'b0;
    #1;
    chk("rstState", 70'(State), 70'(0));
    chk("rstCount", 70'(Count), 70'(0));
    chk("rstValid", 70'(OutValid), 70'(0));
    chk("rstDropped", 70'(Dropped), 70'(0));
    modelReset();
    #1 Reset = 1'b1;
  endtask

  initial begin
    // Reset behaviour before any clock edge
    #1 Reset = 1'b0;
    #1;
    chk("resetState", 70'(State), 70'(0));
    chk("resetCount", 70'(Count), 70'(0));
    chk("resetValid", 70'(OutValid), 70'(0));
    chk("resetDropped", 70'(Dropped), 70'(0));
    modelReset();
    #1 Reset = 1'b1;
    #1;
    chk("relState", 70'(State), 70'(0));
    @(negedge Clk);
    compare();

    // Trigger on PC 0x10 within a short PC stream
    TrigPC = 32'h10; OutReady = 1'b0; StopOnFull = 1'b0;
    armPulse();
    chk("armedState", 70'(State), 70'(1));
    foreach (TrigPC[i]) begin end
    drive(1'b1, 32'h0);  cycle();
    drive(1'b1, 32'h4);  cycle();
    drive(1'b1, 32'h8);  cycle();
    chk("preTrigCount", 70'(Count), 70'(0));
    drive(1'b1, 32'h10); cycle();
    chk("trigState", 70'(State), 70'(2));
    drive(1'b1, 32'h14); cycle();
    chk("trigCount", 70'(Count), 70'(2));
    chk("trigHeadPC", 70'(OutRec[63:32]), 70'(32'h10));

    // Overflow with drop-and-count
    TrigPC = 32'h100;
    armPulse();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i));
      cycle();
    end
    TrValid = 1'b0;
    chk("dropCount", 70'(Count), 70'(8));
    chk("dropDropped", 70'(Dropped), 70'(4));
    chk("dropState", 70'(State), 70'(2));
    chk("dropHeadPC", 70'(OutRec[63:32]), 70'(32'h100));

    // Overflow with halt, then drain in order
    StopOnFull = 1'b1;
    armPulse();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i));
      cycle();
    end
    TrValid = 1'b0;
    chk("haltCount", 70'(Count), 70'(8));
    chk("haltDropped", 70'(Dropped), 70'(0));
    chk("haltState", 70'(State), 70'(3));
    OutReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("popOrder", 70'(OutRec[63:32]), 70'(32'h100 + 32'(4 * i)));
      cycle();
    end
    chk("drainCount", 70'(Count), 70'(0));
    chk("drainValid", 70'(OutValid), 70'(0));

    // Full FIFO with simultaneous push and pop
    StopOnFull = 1'b0; OutReady = 1'b0; TrigPC = 32'h200;
    armPulse();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i));
      cycle();
    end
    chk("fullCount", 70'(Count), 70'(8));
    drive(1'b1, 32'hABC);
    OutReady = 1'b1;
    cycle();
    chk("pushPopCount", 70'(Count), 70'(8));
    chk("pushPopDropped", 70'(Dropped), 70'(0));
    TrValid = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
    chk("lateHeadPC", 70'(OutRec[63:32]), 70'(32'hABC));
    chk("lateCount", 70'(Count), 70'(1));

    // Re-arm mid-capture clears contents
    OutReady = 1'b0; TrigPC = 32'h300;
    armPulse();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i));
      cycle();
    end
    chk("rearmPreCount", 70'(Count), 70'(5));
    armPulse();
    chk("rearmCount", 70'(Count), 70'(0));
    chk("rearmState", 70'(State), 70'(1));

    // Randomized traffic against the model
    TrigPC = 32'h1000;
    for (int n = 0; n < 3000; n++) begin
      Arm = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) StopOnFull = ~StopOnFull;
      if ($urandom_range(0, 199) == 0) TrigPC = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      OutReady = 1'($urandom_range(0, 1));
      drive($urandom_range(0, 9) < 8,
            ($urandom_range(0, 3) == 0) ? TrigPC : 32'h1000 + 32'(4 * $urandom_range(0, 15)));
      cycle();
      if ($urandom_range(0, 399) == 0) asyncReset();
    end
    Arm = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
`default_nettype wire
